// File: rtl/window_collector_kxk.sv
// KxK sliding-window generator over a raster pixel stream with K-1 internal line buffers.
// Optional build macro WINDOW_STRIDE2_EN: emit only windows whose top-left corner is even/even.
module window_collector_kxk #(
  parameter int DATA_W     = 8,
  parameter int K          = 3,
  parameter int MAX_WIDTH  = 8,
  parameter int MAX_HEIGHT = 8,
  localparam int CNT_W     = $clog2(MAX_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      stage_width,
  input  logic [CNT_W-1:0]      stage_height,
  input  logic [DATA_W-1:0]     pixel_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [K*K*DATA_W-1:0] out_window,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  stall,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(MAX_WIDTH);
  localparam logic [CNT_W-1:0] KM1 = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]  col, row, w_q, h_q;
  logic [CNT_W-1:0]  w_eff, h_eff;
  logic [IDX_W-1:0]  col_idx;
  logic              accept, first_px, last_col, last_row, last_px, full, emit;
  logic [DATA_W-1:0] line_buf [K-1][MAX_WIDTH];
  logic [DATA_W-1:0] win      [K][K];
  logic [DATA_W-1:0] col_new  [K];

  assign in_ready = ~out_valid | out_ready;
  assign stall    = ~out_valid;
  assign accept   = in_valid & in_ready;
  assign col_idx  = col[IDX_W-1:0];

  // Frame size is taken live on the very first pixel and from the latch afterwards.
  assign first_px = (col == '0) && (row == '0);
  assign w_eff    = first_px ? stage_width  : w_q;
  assign h_eff    = first_px ? stage_height : h_q;
  assign last_col = (col == w_eff - ONE);
  assign last_row = (row == h_eff - ONE);
  assign last_px  = last_col & last_row;
  assign full     = (row >= KM1) && (col >= KM1);

`ifdef WINDOW_STRIDE2_EN
  // K-1 is even, so the corner parity equals the parity of row/col themselves.
  assign emit = (full & ~row[0] & ~col[0]) | last_px;
`else
  assign emit = full;
`endif

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_new[r] = line_buf[K-2-r][col_idx];
    end
    col_new[K-1] = pixel_in;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][col_idx] <= pixel_in;
      for (int i = 1; i < K - 1; i++) begin
        line_buf[i][col_idx] <= line_buf[i-1][col_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      w_q        <= CNT_W'(K);
      h_q        <= CNT_W'(K);
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      if (first_px) begin
        w_q <= stage_width;
        h_q <= stage_height;
      end
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= col_new[r];
      end
      out_valid  <= emit;
      frame_done <= emit & last_px;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign out_window[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
    end
  end

  sva_legal_size: assert property (@(posedge clk) disable iff (rst)
    (accept && first_px) |->
      (stage_width >= CNT_W'(K) && stage_width <= CNT_W'(MAX_WIDTH) &&
       stage_height >= CNT_W'(K) && stage_height <= CNT_W'(MAX_HEIGHT)));

endmodule

// File: tb/tb_window_collector_kxk.sv
// Randomized self-checking bench for window_collector_kxk (K=3, 8-bit, 8x8 max).
// Expected windows are cut straight out of a stored frame at each accepted pixel.
module tb_window_collector_kxk;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int CW   = 4;
  localparam int TAPW = K * K * DW;
`ifdef WINDOW_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
`else
  localparam bit STRIDE2 = 1'b0;
`endif

  typedef struct packed {
    logic [TAPW-1:0] win;
    logic            fd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   stage_width, stage_height;
  logic [DW-1:0]   pixel_in;
  logic            in_valid, in_ready;
  logic [TAPW-1:0] out_window;
  logic            out_valid, out_ready, stall, frame_done;

  int   n_cmp = 0;
  int   n_err = 0;
  int   frame [8][8];
  exp_t exp_q [$];

  window_collector_kxk #(.DATA_W(DW), .K(K), .MAX_WIDTH(8), .MAX_HEIGHT(8)) dut (
    .clk(clk), .rst(rst), .stage_width(stage_width), .stage_height(stage_height),
    .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
    .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready),
    .stall(stall), .frame_done(frame_done));

  always #5 clk = ~clk;

  function automatic int win_count(input int w, input int h);
    int nr, nc;
    if (!STRIDE2) return (w - K + 1) * (h - K + 1);
    nr = (h - K) / 2 + 1;
    nc = (w - K) / 2 + 1;
    if (((h - K) % 2 == 0) && ((w - K) % 2 == 0)) return nr * nc;
    return nr * nc + 1;
  endfunction

  // Streams the first npix pixels of a w x h frame and checks every output cycle.
  // rmode: 0 = always ready, 1 = ready low for 3 cycles mid-frame, 2 = random valid/ready.
  task automatic run_stream(input int w, input int h, input int pat, input int rmode,
                            input int npix, output int nwin, output int nfd,
                            output logic [TAPW-1:0] first_win);
    bit              emit_a [64];
    int              p, cyc, limit;
    bit              pend, pend_emit, held, hold_fd;
    logic [TAPW-1:0] hold_win;
    exp_t            x;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        frame[r][c] = (pat == 0) ? c : (pat == 1) ? r * 16 + c : int'($urandom_range(0, 255));
      end
    end
    exp_q.delete();
    for (int i = 0; i < npix; i++) begin
      int  r, c;
      bit  full, last, e;
      r    = i / w;
      c    = i % w;
      full = (r >= K - 1) && (c >= K - 1);
      last = (r == h - 1) && (c == w - 1);
      e    = full;
      if (STRIDE2) e = (full && ((r - K + 1) % 2 == 0) && ((c - K + 1) % 2 == 0)) || last;
      emit_a[i] = e;
      if (e) begin
        x.win = '0;
        for (int rr = 0; rr < K; rr++) begin
          for (int cc = 0; cc < K; cc++) begin
            x.win[(rr*K+cc)*DW +: DW] = DW'(frame[r-K+1+rr][c-K+1+cc]);
          end
        end
        x.fd = last;
        exp_q.push_back(x);
      end
    end
    stage_width  = CW'(w);
    stage_height = CW'(h);
    p = 0; cyc = 0; pend = 0; pend_emit = 0; held = 0; hold_fd = 0; hold_win = '0;
    nwin = 0; nfd = 0; first_win = '0;
    limit = npix * 8 + 100;
    while ((p < npix || exp_q.size() != 0 || pend || out_valid) && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      in_valid = (p < npix) && (rmode != 2 || $urandom_range(0, 3) != 0);
      pixel_in = in_valid ? DW'(frame[p/w][p%w]) : DW'($urandom);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 30 && cyc < 33);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (p > 0) begin
        stage_width  = CW'($urandom_range(K, 8));
        stage_height = CW'($urandom_range(K, 8));
      end
      @(negedge clk);
      if (pend) begin
        n_cmp++;
        if (out_valid !== pend_emit) begin
          n_err++;
          $display("FAIL valid_after_accept px=%0d: out_valid=%b want %b", p - 1, out_valid, pend_emit);
        end
      end
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_window !== hold_win || frame_done !== hold_fd) begin
          n_err++;
          $display("FAIL hold_stable: v=%b win=%h fd=%b want v=1 win=%h fd=%b",
                   out_valid, out_window, frame_done, hold_win, hold_fd);
        end
      end
      n_cmp++;
      if (in_ready !== (~out_valid | out_ready)) begin
        n_err++;
        $display("FAIL in_ready: got %b want %b", in_ready, ~out_valid | out_ready);
      end
      n_cmp++;
      if (stall !== ~out_valid) begin
        n_err++;
        $display("FAIL stall: got %b want %b", stall, ~out_valid);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_window: got %h with no window expected", out_window);
        end else begin
          x = exp_q.pop_front();
          if (out_window !== x.win || frame_done !== x.fd) begin
            n_err++;
            $display("FAIL window #%0d: win=%h fd=%b want win=%h fd=%b",
                     nwin, out_window, frame_done, x.win, x.fd);
          end
        end
        if (nwin == 0) first_win = out_window;
        nwin++;
        if (frame_done) nfd++;
      end
      held     = out_valid && !out_ready;
      hold_win = out_window;
      hold_fd  = frame_done;
      pend     = 0;
      if (in_valid && in_ready) begin
        pend      = 1;
        pend_emit = emit_a[p];
        p++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (cyc >= limit || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_done: cycles=%0d pending=%0d want <%0d and 0", cyc, exp_q.size(), limit);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || out_window !== '0 || frame_done !== 1'b0 ||
        stall !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: v=%b win=%h fd=%b stall=%b rdy=%b want 0 0 0 1 1",
               out_valid, out_window, frame_done, stall, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nwin, nfd;
    logic [TAPW-1:0] fw;
    run_stream(8, 8, 0, 0, 64, nwin, nfd, fw);
    n_cmp++;
    if (nwin !== win_count(8, 8)) begin
      n_err++; $display("FAIL basic_count: got %0d want %0d", nwin, win_count(8, 8));
    end
    n_cmp++;
    if (nfd !== 1) begin
      n_err++; $display("FAIL basic_frame_done: got %0d want 1", nfd);
    end
    n_cmp++;
    if (fw !== 72'h02_01_00_02_01_00_02_01_00) begin
      n_err++; $display("FAIL basic_first_window: got %h want 020100020100020100", fw);
    end
  endtask

  task automatic test_hold();
    int nwin, nfd;
    logic [TAPW-1:0] fw;
    run_stream(8, 8, 0, 1, 64, nwin, nfd, fw);
    n_cmp++;
    if (nwin !== win_count(8, 8) || nfd !== 1) begin
      n_err++;
      $display("FAIL hold_count: got %0d/%0d want %0d/1", nwin, nfd, win_count(8, 8));
    end
  endtask

  task automatic test_small_frame();
    int nwin, nfd;
    logic [TAPW-1:0] fw;
    run_stream(5, 4, 1, 0, 20, nwin, nfd, fw);
    n_cmp++;
    if (nwin !== win_count(5, 4) || nfd !== 1) begin
      n_err++;
      $display("FAIL small_count: got %0d/%0d want %0d/1", nwin, nfd, win_count(5, 4));
    end
    n_cmp++;
    if (fw !== 72'h22_21_20_12_11_10_02_01_00) begin
      n_err++; $display("FAIL small_first_window: got %h want 222120121110020100", fw);
    end
  endtask

  task automatic test_mid_frame_reset();
    int nwin, nfd;
    logic [TAPW-1:0] fw;
    run_stream(8, 8, 0, 0, 20, nwin, nfd, fw);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    pixel_in  = 8'd4;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_valid: got %b want 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_window !== '0 || frame_done !== 1'b0 ||
        stall !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: v=%b win=%h fd=%b stall=%b rdy=%b want 0 0 0 1 1",
               out_valid, out_window, frame_done, stall, in_ready);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    run_stream(8, 8, 0, 0, 64, nwin, nfd, fw);
    n_cmp++;
    if (nwin !== win_count(8, 8) || nfd !== 1) begin
      n_err++;
      $display("FAIL post_reset_count: got %0d/%0d want %0d/1", nwin, nfd, win_count(8, 8));
    end
  endtask

  task automatic test_random_frames();
    int nwin, nfd, w, h;
    logic [TAPW-1:0] fw;
    for (int f = 0; f < 5; f++) begin
      w = $urandom_range(K, 8);
      h = $urandom_range(K, 8);
      run_stream(w, h, 2, 2, w * h, nwin, nfd, fw);
      n_cmp++;
      if (nwin !== win_count(w, h) || nfd !== 1) begin
        n_err++;
        $display("FAIL random_count %0dx%0d: got %0d/%0d want %0d/1", w, h, nwin, nfd, win_count(w, h));
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pixel_in = '0;
    stage_width = CW'(8); stage_height = CW'(8);
    test_reset();
    test_basic();
    test_hold();
    test_small_frame();
    test_mid_frame_reset();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
